// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding the decoder.
// Owns the instruction pointer and issues word reads over req/gnt/rvalid.
// Returned words are buffered with their addresses in an in-order FIFO.
// A taken jump (redirect) flushes the FIFO and marks every read still in
// flight as stale, so its response is discarded when it returns.
// Optional: define FETCH_STATS_EN to add saturating statistics counters.
module fetch_unit #(
    parameter int              IP_W     = 16,
    parameter int              DEPTH    = 4,
    parameter logic [IP_W-1:0] RESET_IP = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            mem_req,
    output logic [IP_W-1:0] mem_addr,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [31:0]     mem_rdata,
    output logic            op_valid,
    input  logic            op_ready,
    output logic [31:0]     op,
    output logic [IP_W-1:0] op_ip,
    input  logic            redirect,
    input  logic [IP_W-1:0] redirect_ip
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0]     stat_stall_cycles,
    output logic [31:0]     stat_flushes,
    output logic [31:0]     stat_dropped
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W:0]   DEPTH_S = (CNT_W + 1)'(DEPTH);

    logic [IP_W-1:0]  fetch_ip;
    logic [IP_W-1:0]  resp_ip;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] outstanding_nxt;
    logic [CNT_W-1:0] drop_cnt;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [31:0]      fifo_op [DEPTH];
    logic [IP_W-1:0]  fifo_ip [DEPTH];

    logic [CNT_W:0] inflight;
    logic           accept;
    logic           discard;
    logic           push;
    logic           pop;

    // Buffered words plus reads in flight may never exceed the FIFO size,
    // which is what guarantees room for every response.
    assign inflight = {1'b0, count} + {1'b0, outstanding};
    assign mem_req  = rst_n && !redirect && (inflight < DEPTH_S);
    assign mem_addr = fetch_ip;
    assign accept   = mem_req && mem_gnt;

    // A response is stale if it was in flight at a redirect, or arrives with one.
    assign discard  = mem_rvalid && (redirect || (drop_cnt != '0));
    assign push     = mem_rvalid && !discard;
    assign pop      = op_valid && op_ready && !redirect;

    assign op_valid = (count != '0);
    assign op       = op_valid ? fifo_op[rd_ptr] : '0;
    assign op_ip    = op_valid ? fifo_ip[rd_ptr] : '0;

    // Reads in flight after this cycle's grant and response.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        outstanding_nxt = outstanding;
        if (accept && !mem_rvalid) outstanding_nxt = outstanding + CNT_W'(1);
        if (!accept && mem_rvalid) outstanding_nxt = outstanding - CNT_W'(1);
    end

    // Instruction pointers and stale-response bookkeeping; redirect wins.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (!rst_n) begin
            fetch_ip    <= RESET_IP;
            resp_ip     <= RESET_IP;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= outstanding_nxt;
            if (redirect) begin
                fetch_ip <= redirect_ip;
                resp_ip  <= redirect_ip;
                drop_cnt <= outstanding_nxt;
            end else begin
                if (accept) fetch_ip <= fetch_ip + IP_W'(1);
                if (push) resp_ip <= resp_ip + IP_W'(1);
                if (mem_rvalid && (drop_cnt != '0)) drop_cnt <= drop_cnt - CNT_W'(1);
            end
        end
    end

    // FIFO pointers and occupancy; a redirect empties the buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (redirect) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop) count <= count + CNT_W'(1);
            if (!push && pop) count <= count - CNT_W'(1);
        end
    end

    // FIFO storage: op word and its address.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; op/op_ip are gated by op_valid so stale entries never reach the decoder.
        if (push) begin
            fifo_op[wr_ptr] <= mem_rdata;
            fifo_ip[wr_ptr] <= resp_ip;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && (count == DEPTH_C)));
    a_inflight_bound: assert property (@(posedge clk) disable iff (!rst_n)
        inflight <= DEPTH_S);
    a_no_spurious_rvalid: assert property (@(posedge clk) disable iff (!rst_n)
        !(mem_rvalid && (outstanding == '0)));

`ifdef FETCH_STATS_EN
    // Saturating statistics counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_stall_cycles <= '0;
            stat_flushes      <= '0;
            stat_dropped      <= '0;
        end else begin
            if (!op_valid && !redirect && (stat_stall_cycles != '1))
                stat_stall_cycles <= stat_stall_cycles + 32'd1;
            if (redirect && (stat_flushes != '1))
                stat_flushes <= stat_flushes + 32'd1;
            if (discard && (stat_dropped != '1))
                stat_dropped <= stat_dropped + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized bench for fetch_unit against a transaction-level
// model. The model tags each read with a redirect epoch; a response whose
// epoch is older than the current one is stale. Decoder-visible state is a
// queue of {ip, word}.
module tb_fetch_unit;

    localparam int          IP_W     = 16;
    localparam int          DEPTH    = 4;
    localparam logic [15:0] RESET_IP = 16'h0000;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            mem_req;
    logic [IP_W-1:0] mem_addr;
    logic            mem_gnt = 1'b0;
    logic            mem_rvalid = 1'b0;
    logic [31:0]     mem_rdata = '0;
    logic            op_valid;
    logic            op_ready = 1'b0;
    logic [31:0]     op;
    logic [IP_W-1:0] op_ip;
    logic            redirect = 1'b0;
    logic [IP_W-1:0] redirect_ip = '0;
`ifdef FETCH_STATS_EN
    logic [31:0]     stat_stall_cycles;
    logic [31:0]     stat_flushes;
    logic [31:0]     stat_dropped;
`endif

    fetch_unit #(.IP_W(IP_W), .DEPTH(DEPTH), .RESET_IP(RESET_IP)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_gnt     (mem_gnt),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .op_valid    (op_valid),
        .op_ready    (op_ready),
        .op          (op),
        .op_ip       (op_ip),
        .redirect    (redirect),
        .redirect_ip (redirect_ip)
`ifdef FETCH_STATS_EN
        ,
        .stat_stall_cycles (stat_stall_cycles),
        .stat_flushes      (stat_flushes),
        .stat_dropped      (stat_dropped)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        int          epoch;
        int          due;
    } pend_t;

    typedef struct {
        logic [15:0] ip;
        logic [31:0] data;
    } op_t;

    pend_t       pend[$];
    op_t         q[$];
    logic [15:0] fetch_ip;
    int          epoch;
    int          cyc;
    logic        exp_req;

    int   n_tests = 0;
    int   n_fail  = 0;

    int   gnt_pct, lat_min, lat_max, rdy_pct, redir_pct;
    logic force_redir = 1'b0;
    logic [15:0] force_ip = '0;

    // Memory contents as a function of address.
    function automatic logic [31:0] mem_word(input logic [15:0] a);
        return {16'(a ^ 16'h5A3C), 16'(~a + 16'h0101)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: bound expired at cycle %0d", name, cyc);
    endtask

    // Entry at posedge+1: drive inputs, then compare DUT outputs at the negedge.
    task automatic drive_and_check();
        mem_gnt     = ($urandom_range(0, 99) < gnt_pct);
        op_ready    = ($urandom_range(0, 99) < rdy_pct);
        redirect    = force_redir || ($urandom_range(0, 99) < redir_pct);
        redirect_ip = force_redir ? force_ip : 16'($urandom);
        force_redir = 1'b0;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            mem_rvalid = 1'b1;
            mem_rdata  = mem_word(pend[0].addr);
        end else begin
            mem_rvalid = 1'b0;
            mem_rdata  = $urandom;
        end
        #4;
        exp_req = !redirect && ((q.size() + pend.size()) < DEPTH);
        check("mem_req", 32'(mem_req), 32'(exp_req));
        if (exp_req) check("mem_addr", 32'(mem_addr), 32'(fetch_ip));
        check("op_valid", 32'(op_valid), 32'(q.size() > 0));
        if (q.size() > 0) begin
            check("op", op, q[0].data);
            check("op_ip", 32'(op_ip), 32'(q[0].ip));
        end
    endtask

    // Apply this cycle's transactions to the model, then move to posedge+1.
    task automatic advance();
        pend_t r;
        int    due;
        if (redirect) begin
            q.delete();
            fetch_ip = redirect_ip;
            epoch++;
            if (mem_rvalid) void'(pend.pop_front());
        end else begin
            if (q.size() > 0 && op_ready) void'(q.pop_front());
            if (mem_rvalid) begin
                r = pend.pop_front();
                if (r.epoch == epoch) q.push_back('{ip: r.addr, data: mem_word(r.addr)});
            end
            if (exp_req && mem_gnt) begin
                due = cyc + $urandom_range(lat_min, lat_max);
                if (pend.size() > 0 && due < pend[$].due) due = pend[$].due;
                pend.push_back('{addr: fetch_ip, epoch: epoch, due: due});
                fetch_ip = fetch_ip + 16'd1;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic step();
        drive_and_check();
        advance();
    endtask

    // Asynchronous reset from any step boundary; memory is reset alongside.
    task automatic do_reset();
        rst_n      = 1'b0;
        redirect   = 1'b0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        op_ready   = 1'b0;
        #1;
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'(RESET_IP));
        check("rst_op_valid", 32'(op_valid), 32'd0);
        check("rst_op", op, 32'd0);
        check("rst_op_ip", 32'(op_ip), 32'd0);
        pend.delete();
        q.delete();
        fetch_ip = RESET_IP;
        epoch    = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          grants;
        bit          seen;
        logic [15:0] got[$];

        gnt_pct = 100; lat_min = 1; lat_max = 1; rdy_pct = 100; redir_pct = 0;
        cyc = 0;
        @(posedge clk);
        #1;
        do_reset();

        // Zero-wait memory, decoder always ready: steady stream 0,1,2,...
        for (int k = 0; k < 20; k++) begin
            drive_and_check();
            if (k >= 2) begin
                check("zw_valid", 32'(op_valid), 32'd1);
                check("zw_ip", 32'(op_ip), 32'(k - 2));
            end
            advance();
        end

        // Decoder stalled: exactly DEPTH grants, then issue stops.
        do_reset();
        rdy_pct = 0;
        grants  = 0;
        for (int k = 0; k < 10; k++) begin
            drive_and_check();
            if (mem_req && mem_gnt) grants++;
            advance();
        end
        check("stall_grants", 32'(grants), 32'd4);
        rdy_pct = 100;
        seen = 1'b0;
        for (int k = 0; k < 6 && !seen; k++) begin
            drive_and_check();
            if (mem_req) begin
                seen = 1'b1;
                check("resume_addr", 32'(mem_addr), 32'h4);
            end
            advance();
        end
        if (!seen) timeout_fail("resume_addr");
        for (int k = 0; k < 12; k++) step();

        // Latency 3, redirect with two reads outstanding.
        do_reset();
        lat_min = 3; lat_max = 3;
        for (int k = 0; k < 3; k++) begin
            gnt_pct = (k < 2) ? 100 : 0;
            if (k == 2) begin force_redir = 1'b1; force_ip = 16'h0100; end
            step();
        end
        gnt_pct = 100;
        drive_and_check();
        check("post_redir_valid", 32'(op_valid), 32'd0);
        advance();
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            drive_and_check();
            if (op_valid) begin
                seen = 1'b1;
                check("redir_first_ip", 32'(op_ip), 32'h0100);
            end
            advance();
        end
        if (!seen) timeout_fail("redir_first_ip");

        // Redirect coinciding with rvalid and gnt.
        do_reset();
        lat_min = 2; lat_max = 2; gnt_pct = 100;
        step();
        step();
        force_redir = 1'b1; force_ip = 16'h0200;
        step();
        drive_and_check();
        check("coinc_valid", 32'(op_valid), 32'd0);
        advance();
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            drive_and_check();
            if (op_valid) begin
                seen = 1'b1;
                check("coinc_first_ip", 32'(op_ip), 32'h0200);
            end
            advance();
        end
        if (!seen) timeout_fail("coinc_first_ip");

        // Address wrap past 0xFFFF.
        lat_min = 1; lat_max = 1;
        force_redir = 1'b1; force_ip = 16'hFFFE;
        for (int k = 0; k < 30; k++) begin
            drive_and_check();
            if (op_valid && op_ready && !redirect) got.push_back(op_ip);
            advance();
        end
        if (got.size() >= 3) begin
            check("wrap_ip0", 32'(got[0]), 32'hFFFE);
            check("wrap_ip1", 32'(got[1]), 32'hFFFF);
            check("wrap_ip2", 32'(got[2]), 32'h0000);
        end else begin
            timeout_fail("wrap_ops");
        end

        // Reset mid-stream with reads outstanding.
        lat_min = 3; lat_max = 3; rdy_pct = 50;
        for (int k = 0; k < 7; k++) step();
        do_reset();
        rdy_pct = 100; lat_min = 1; lat_max = 1;
        drive_and_check();
        check("after_rst_req", 32'(mem_req), 32'd1);
        check("after_rst_addr", 32'(mem_addr), 32'(RESET_IP));
        advance();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if (i % 250 == 0) begin
                gnt_pct   = $urandom_range(30, 100);
                lat_min   = 1;
                lat_max   = $urandom_range(1, 5);
                rdy_pct   = $urandom_range(20, 100);
                redir_pct = $urandom_range(0, 8);
            end
            if (i == 1500) do_reset();
            if ($urandom_range(0, 99) == 0) begin
                force_redir = 1'b1;
                force_ip    = 16'hFFFD;
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
